// File: rtl/bsg_manycore_endpoint_credited.sv
// Manycore link endpoint: splits one link into in/out request and response streams,
// tracks outstanding-request credits and flags protocol errors (sticky until reset).
module bsg_manycore_endpoint_credited #(
  parameter int unsigned x_cord_width_p    = 4,
  parameter int unsigned y_cord_width_p    = 4,
  parameter int unsigned data_width_p      = 32,
  parameter int unsigned addr_width_p      = 32,
  parameter int unsigned fwd_fifo_els_p    = 2,
  parameter int unsigned rev_fifo_els_p    = 16,
  parameter int unsigned max_out_credits_p = 16,
  // request = op/mask(4) + addr + data + src/dst coords; response = type(2) + data + dst coords
  localparam int unsigned packet_width_lp        = 4 + addr_width_p + data_width_p
                                                   + 2 * (x_cord_width_p + y_cord_width_p),
  localparam int unsigned return_packet_width_lp = 2 + data_width_p + x_cord_width_p + y_cord_width_p,
  localparam int unsigned link_sif_width_lp      = packet_width_lp + return_packet_width_lp + 4,
  localparam int unsigned credit_width_lp        = $clog2(max_out_credits_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [link_sif_width_lp-1:0]      link_sif_i,
  output logic [link_sif_width_lp-1:0]      link_sif_o,
  output logic [packet_width_lp-1:0]        packet_o,
  output logic                              packet_v_o,
  input  logic                              packet_yumi_i,
  input  logic [return_packet_width_lp-1:0] return_packet_i,
  input  logic                              return_packet_v_i,
  output logic                              return_packet_ready_o,
  input  logic [packet_width_lp-1:0]        packet_i,
  input  logic                              packet_v_i,
  output logic                              packet_ready_o,
  output logic [return_packet_width_lp-1:0] return_packet_o,
  output logic                              return_packet_v_o,
  input  logic                              return_packet_yumi_i,
  output logic [credit_width_lp-1:0]        out_credits_used_o,
  output logic                              idle_o,
  output logic                              protocol_error_o
);
  localparam int unsigned PW = packet_width_lp;
  localparam int unsigned RW = return_packet_width_lp;

  // Link layout, MSB first: {fwd.v, fwd.data, fwd.ready_and_rev, rev.v, rev.data, rev.ready_and_rev}
  logic          w_in_fwd_v, w_in_fwd_ready, w_in_rev_v, w_in_rev_ready;
  logic [PW-1:0] w_in_fwd_data;
  logic [RW-1:0] w_in_rev_data;

  assign w_in_fwd_v     = link_sif_i[RW+PW+3];
  assign w_in_fwd_data  = link_sif_i[RW+PW+2:RW+3];
  assign w_in_fwd_ready = link_sif_i[RW+2];
  assign w_in_rev_v     = link_sif_i[RW+1];
  assign w_in_rev_data  = link_sif_i[RW:1];
  assign w_in_rev_ready = link_sif_i[0];

  logic                       w_fwd_full, w_fwd_v, w_fwd_ready, w_fwd_enq, w_fwd_deq;
  logic                       w_rev_full, w_rev_v, w_rev_enq, w_rev_drop, w_ret_deq;
  logic                       w_credit_avail, w_send, w_out_fwd_v, w_underflow, w_yumi_err;
  logic [credit_width_lp-1:0] r_credits;
  logic                       r_error;

  assign w_fwd_ready = reset_n_i & ~w_fwd_full;
  assign w_fwd_enq   = w_in_fwd_v & w_fwd_ready;
  assign packet_v_o  = reset_n_i & w_fwd_v;
  assign w_fwd_deq   = packet_yumi_i & packet_v_o;

  bsg_mce_fifo #(.width_p(PW), .els_p(fwd_fifo_els_p)) fwd_fifo (
    .clk_i, .reset_n_i, .enq_i(w_fwd_enq), .deq_i(w_fwd_deq), .data_i(w_in_fwd_data),
    .data_o(packet_o), .v_o(w_fwd_v), .full_o(w_fwd_full)
  );

  // Responses are always accepted; a full FIFO only takes one when it is also draining.
  assign return_packet_v_o = reset_n_i & w_rev_v;
  assign w_ret_deq         = return_packet_yumi_i & return_packet_v_o;
  assign w_rev_enq         = reset_n_i & w_in_rev_v & (~w_rev_full | w_ret_deq);
  assign w_rev_drop        = reset_n_i & w_in_rev_v & w_rev_full & ~w_ret_deq;

  bsg_mce_fifo #(.width_p(RW), .els_p(rev_fifo_els_p)) rev_fifo (
    .clk_i, .reset_n_i, .enq_i(w_rev_enq), .deq_i(w_ret_deq), .data_i(w_in_rev_data),
    .data_o(return_packet_o), .v_o(w_rev_v), .full_o(w_rev_full)
  );

  assign w_credit_avail = r_credits < credit_width_lp'(max_out_credits_p);
  assign packet_ready_o = reset_n_i & w_in_fwd_ready & w_credit_avail;
  assign w_send         = packet_v_i & packet_ready_o;
  assign w_out_fwd_v    = reset_n_i & packet_v_i & w_credit_avail;

  assign return_packet_ready_o = w_in_rev_ready;
  assign link_sif_o = {w_out_fwd_v, packet_i, w_fwd_ready,
                       return_packet_v_i, return_packet_i, reset_n_i};

  assign w_underflow = w_ret_deq & ~w_send & (r_credits == '0);
  assign w_yumi_err  = (packet_yumi_i & ~packet_v_o) | (return_packet_yumi_i & ~return_packet_v_o);

  // Credits return when the response is consumed, not when it arrives.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_credits <= '0;
      r_error   <= 1'b0;
    end else begin
      if (w_send & ~w_ret_deq)
        r_credits <= r_credits + credit_width_lp'(1);
      else if (~w_send & w_ret_deq & (r_credits != '0))
        r_credits <= r_credits - credit_width_lp'(1);
      r_error <= r_error | w_rev_drop | w_underflow | w_yumi_err;
    end
  end

  assign out_credits_used_o = r_credits;
  assign idle_o             = ~reset_n_i | (r_credits == '0);
  assign protocol_error_o   = r_error;
endmodule

// Simple circular FIFO; head is visible the cycle after enqueue, enq+deq allowed together.
module bsg_mce_fifo #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               enq_i,
  input  logic               deq_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  output logic               full_o
);
  localparam int unsigned PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned CNT_W = $clog2(els_p + 1);

  logic [width_p-1:0] r_mem [els_p];
  logic [PTR_W-1:0]   r_rd, r_wr;
  logic [CNT_W-1:0]   r_cnt;

  always_ff @(posedge clk_i) begin
    if (enq_i) r_mem[r_wr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (enq_i) r_wr <= (r_wr == PTR_W'(els_p - 1)) ? '0 : r_wr + PTR_W'(1);
      if (deq_i) r_rd <= (r_rd == PTR_W'(els_p - 1)) ? '0 : r_rd + PTR_W'(1);
      case ({enq_i, deq_i})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign data_o = r_mem[r_rd];
  assign v_o    = (r_cnt != '0);
  assign full_o = (r_cnt == CNT_W'(els_p));
endmodule
